// File: rtl/dca_lpixm_sram_responder.sv
// LPI-XM responder backed by an internal word-addressed register memory.
// Optional WRAP burst support is enabled by defining DCA_LPIXM_SRAM_RESPONDER_WRAP_EN.
module dca_lpixm_sram_responder #(
   parameter int BW_ADDR       = 32,
   parameter int BW_DATA       = 32,
   parameter int BW_LPI_BURDEN = 1,
   parameter int DEPTH_LOG2    = 8
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     clear,
   output logic                     busy,
   output logic [1:0]               slxqdready,
   input  logic                     slxqvalid,
   input  logic                     slxqlast,
   input  logic                     slxqwrite,
   input  logic [7:0]               slxqlen,
   input  logic [2:0]               slxqsize,
   input  logic [1:0]               slxqburst,
   input  logic [BW_DATA/8-1:0]     slxqwstrb,
   input  logic [BW_DATA-1:0]       slxqwdata,
   input  logic [BW_ADDR-1:0]       slxqaddr,
   input  logic [BW_LPI_BURDEN-1:0] slxqburden,
   input  logic [1:0]               slxydready,
   output logic                     slxyvalid,
   output logic                     slxylast,
   output logic                     slxywreply,
   output logic [1:0]               slxyresp,
   output logic [BW_DATA-1:0]       slxyrdata,
   output logic [BW_LPI_BURDEN-1:0] slxyburden
);
   localparam int NB    = BW_DATA / 8;
   localparam int A     = $clog2(NB);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WDATA, WREPLY, READ} state_t;

   typedef struct packed {
      logic [BW_ADDR-1:0]       addr;
      logic [7:0]               len;
      logic [2:0]               size;
      logic [1:0]               burst;
      logic [BW_LPI_BURDEN-1:0] burden;
   } req_t;

   state_t                state, nstate;
   req_t                  cur, beat;
   logic [7:0]            cnt;
   logic                  werr;
   logic                  q_fire, y_fire;
   logic                  beat_oor, beat_err, mem_we;
   logic [DEPTH_LOG2-1:0] widx;
   logic [BW_DATA-1:0]    mem [DEPTH];
   logic                  unused_bits;

   // Whole-burst error: oversize beats, reserved burst type, unsupported wrap.
   function automatic logic burst_bad(input req_t r);
      logic bad;
      bad = (r.size > 3'(A)) || (r.burst == 2'd3);
`ifdef DCA_LPIXM_SRAM_RESPONDER_WRAP_EN
      if (r.burst == 2'd2 && !(r.len inside {8'd1, 8'd3, 8'd7, 8'd15})) bad = 1'b1;
`else
      if (r.burst == 2'd2) bad = 1'b1;
`endif
      return bad;
   endfunction

   function automatic logic [BW_ADDR-1:0] next_addr(input req_t r);
      logic [BW_ADDR-1:0] step, mask, na;
      step = BW_ADDR'(1) << r.size;
      mask = ((BW_ADDR'(r.len) + BW_ADDR'(1)) << r.size) - BW_ADDR'(1);
      case (r.burst)
         2'd0:    na = r.addr;
         2'd2:    na = (r.addr & ~mask) | ((r.addr + step) & mask);
         default: na = r.addr + step;
      endcase
      return na;
   endfunction

   // The first write beat is serviced straight from the request; later beats use latched fields.
   always_comb begin
      beat = cur;
      if (state == IDLE) begin
         beat.addr   = slxqaddr;
         beat.len    = slxqlen;
         beat.size   = slxqsize;
         beat.burst  = slxqburst;
         beat.burden = slxqburden;
      end
   end

   assign beat_oor    = |(beat.addr >> (DEPTH_LOG2 + A));
   assign beat_err    = burst_bad(beat) | beat_oor;
   assign widx        = beat.addr[DEPTH_LOG2+A-1:A];
   assign q_fire      = slxqvalid & slxqdready[0];
   assign y_fire      = slxyvalid & slxydready[0];
   assign busy        = (state != IDLE);
   assign unused_bits = slxydready[1];

   assign mem_we = q_fire & ~clear & ~beat_err &
                   (((state == IDLE) & slxqwrite) | (state == WDATA));

   always_ff @(posedge clk) begin
      if (mem_we)
         for (int b = 0; b < NB; b++)
            if (slxqwstrb[b]) mem[widx][b*8 +: 8] <= slxqwdata[b*8 +: 8];
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (q_fire) nstate = slxqwrite ? (slxqlast ? WREPLY : WDATA) : READ;
         WDATA:   if (q_fire && slxqlast) nstate = WREPLY;
         WREPLY:  if (y_fire) nstate = IDLE;
         READ:    if (y_fire && cnt == cur.len) nstate = IDLE;
         default: nstate = IDLE;
      endcase
      if (clear) nstate = IDLE;
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         cur  <= '0;
         cnt  <= '0;
         werr <= 1'b0;
      end else if (!clear) begin
         case (state)
            IDLE: if (q_fire) begin
               cur  <= beat;
               cnt  <= '0;
               werr <= beat_err;
               if (slxqwrite) cur.addr <= next_addr(beat);
            end
            WDATA: if (q_fire) begin
               cur.addr <= next_addr(cur);
               werr     <= werr | beat_err;
            end
            READ: if (y_fire) begin
               cur.addr <= next_addr(cur);
               cnt      <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      slxqdready = 2'b00;
      slxyvalid  = 1'b0;
      slxylast   = 1'b0;
      slxywreply = 1'b0;
      slxyresp   = 2'd0;
      slxyrdata  = '0;
      slxyburden = '0;
      case (state)
         IDLE, WDATA: slxqdready = 2'b11;
         WREPLY: begin
            slxyvalid  = 1'b1;
            slxylast   = 1'b1;
            slxywreply = 1'b1;
            slxyresp   = werr ? 2'd2 : 2'd0;
            slxyburden = cur.burden;
         end
         READ: begin
            slxyvalid  = 1'b1;
            slxylast   = (cnt == cur.len);
            slxyresp   = beat_err ? 2'd2 : 2'd0;
            slxyrdata  = beat_err ? '0 : mem[widx];
            slxyburden = cur.burden;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dca_lpixm_sram_responder.sv
// Directed bench for dca_lpixm_sram_responder: single-beat vector table plus burst,
// backpressure, wrap and clear sequences.
module tb_dca_lpixm_sram_responder;
   logic        clk = 1'b0;
   logic        rstnn, clear, busy;
   logic [1:0]  slxqdready, slxqburst, slxydready, slxyresp;
   logic        slxqvalid, slxqlast, slxqwrite;
   logic [7:0]  slxqlen;
   logic [2:0]  slxqsize;
   logic [3:0]  slxqwstrb;
   logic [31:0] slxqwdata, slxqaddr, slxyrdata;
   logic [0:0]  slxqburden, slxyburden;
   logic        slxyvalid, slxylast, slxywreply;

   int total = 0;
   int bad   = 0;

   logic [31:0] wbuf [16];
   logic [31:0] rdat [16];
   logic [1:0]  rrsp [16];
   int          nb, nlast, lastpos, cyc;
   logic        bdn;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [31:0] er;
      logic [1:0]  ep;
   } vec_t;
   vec_t tbl [17];

   always #5 clk = ~clk;

   dca_lpixm_sram_responder dut (
      .clk(clk), .rstnn(rstnn), .clear(clear), .busy(busy),
      .slxqdready(slxqdready), .slxqvalid(slxqvalid), .slxqlast(slxqlast),
      .slxqwrite(slxqwrite), .slxqlen(slxqlen), .slxqsize(slxqsize),
      .slxqburst(slxqburst), .slxqwstrb(slxqwstrb), .slxqwdata(slxqwdata),
      .slxqaddr(slxqaddr), .slxqburden(slxqburden), .slxydready(slxydready),
      .slxyvalid(slxyvalid), .slxylast(slxylast), .slxywreply(slxywreply),
      .slxyresp(slxyresp), .slxyrdata(slxyrdata), .slxyburden(slxyburden)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_burst(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] st, output logic [1:0] resp);
      int w;
      for (int i = 0; i <= len; i++) begin
         slxqvalid  = 1'b1;
         slxqwrite  = 1'b1;
         slxqaddr   = (i == 0) ? a : 32'hFFFF_FFF0;
         slxqlen    = 8'(len);
         slxqsize   = sz;
         slxqburst  = bu;
         slxqwstrb  = st;
         slxqwdata  = wbuf[i];
         slxqlast   = (i == len);
         slxqburden = bdn;
         w = 0;
         while (slxqdready[0] !== 1'b1 && w < 20) begin tick(); w++; end
         if (w >= 20) chk("wr_ready_timeout", 64'(slxqdready), 64'd3);
         tick();
      end
      slxqvalid = 1'b0;
      slxqlast  = 1'b0;
      chk("wr_reply_latency", 64'(slxyvalid), 64'd1);
      chk("wr_reply_flags", 64'({slxywreply, slxylast, slxyrdata}), 64'({2'b11, 32'h0}));
      chk("wr_burden", 64'(slxyburden), 64'(bdn));
      resp = slxyresp;
      tick();
      chk("wr_idle_after", 64'({busy, slxyvalid}), 64'd0);
   endtask

   task automatic rd_burst(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input logic [1:0] bu, input bit tog);
      logic [35:0] held;
      bit          hv;
      int          k;
      slxqvalid  = 1'b1;
      slxqwrite  = 1'b0;
      slxqaddr   = a;
      slxqlen    = 8'(len);
      slxqsize   = sz;
      slxqburst  = bu;
      slxqlast   = 1'b1;
      slxqburden = bdn;
      tick();
      slxqvalid = 1'b0;
      chk("rd_first_latency", 64'(slxyvalid), 64'd1);
      chk("rd_burden", 64'(slxyburden), 64'(bdn));
      nb = 0; nlast = 0; lastpos = -1; hv = 0; k = 0; held = '0;
      while (nb <= len && k < 100) begin
         slxydready = (tog && k[0]) ? 2'b00 : 2'b01;
         if (hv) chk("rd_hold", 64'({slxyvalid, slxylast, slxyresp, slxyrdata}), 64'(held));
         if (slxyvalid && slxydready[0]) begin
            rdat[nb] = slxyrdata;
            rrsp[nb] = slxyresp;
            if (slxylast) begin nlast++; lastpos = nb; end
            nb++;
            hv = 0;
         end else begin
            held = {slxyvalid, slxylast, slxyresp, slxyrdata};
            hv = 1;
         end
         tick();
         k++;
      end
      slxydready = 2'b01;
      cyc = k;
      chk("rd_beats", 64'(nb), 64'(len + 1));
      chk("rd_single_last", 64'(nlast), 64'd1);
      chk("rd_last_pos", 64'(lastpos), 64'(len));
      chk("rd_idle_after", 64'({busy, slxyvalid}), 64'd0);
   endtask

   initial begin
      logic [1:0] resp;
      rstnn = 1'b0; clear = 1'b0; slxqvalid = 1'b0; slxqlast = 1'b0; slxqwrite = 1'b0;
      slxqlen = '0; slxqsize = 3'd2; slxqburst = 2'd1; slxqwstrb = '0; slxqwdata = '0;
      slxqaddr = '0; slxqburden = '0; slxydready = 2'b01; bdn = 1'b0;

      //             wr  addr           sz    bu    wdata          strb  exp_rdata      exp_resp
      tbl[0]  = '{1, 32'h0000_0020, 3'd2, 2'd1, 32'hAABB_CCDD, 4'hF, 32'h0,         2'd0};
      tbl[1]  = '{1, 32'h0000_0020, 3'd2, 2'd1, 32'h0000_1100, 4'h2, 32'h0,         2'd0};
      tbl[2]  = '{0, 32'h0000_0020, 3'd2, 2'd1, 32'h0,         4'h0, 32'hAABB_11DD, 2'd0};
      tbl[3]  = '{1, 32'h0000_03FC, 3'd2, 2'd1, 32'h1234_5678, 4'hF, 32'h0,         2'd0};
      tbl[4]  = '{0, 32'h0000_03FC, 3'd2, 2'd1, 32'h0,         4'h0, 32'h1234_5678, 2'd0};
      tbl[5]  = '{1, 32'h0000_0000, 3'd2, 2'd1, 32'h0BAD_F00D, 4'hF, 32'h0,         2'd0};
      tbl[6]  = '{0, 32'h0000_0400, 3'd2, 2'd1, 32'h0,         4'h0, 32'h0,         2'd2};
      tbl[7]  = '{1, 32'h0000_0400, 3'd2, 2'd1, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'd2};
      tbl[8]  = '{0, 32'h0000_0000, 3'd2, 2'd1, 32'h0,         4'h0, 32'h0BAD_F00D, 2'd0};
      tbl[9]  = '{0, 32'h0000_0020, 3'd3, 2'd1, 32'h0,         4'h0, 32'h0,         2'd2};
      tbl[10] = '{1, 32'h0000_0024, 3'd2, 2'd1, 32'h0000_0055, 4'hF, 32'h0,         2'd0};
      tbl[11] = '{1, 32'h0000_0024, 3'd2, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'd2};
      tbl[12] = '{0, 32'h0000_0024, 3'd2, 2'd1, 32'h0,         4'h0, 32'h0000_0055, 2'd0};
      tbl[13] = '{0, 32'h0000_0020, 3'd2, 2'd0, 32'h0,         4'h0, 32'hAABB_11DD, 2'd0};
      tbl[14] = '{0, 32'h2000_0000, 3'd2, 2'd1, 32'h0,         4'h0, 32'h0,         2'd2};
      tbl[15] = '{1, 32'h0000_0020, 3'd3, 2'd1, 32'h0,         4'hF, 32'h0,         2'd2};
      tbl[16] = '{0, 32'h0000_0020, 3'd2, 2'd1, 32'h0,         4'h0, 32'hAABB_11DD, 2'd0};

      repeat (2) tick();
      chk("reset_ready", 64'(slxqdready), 64'd3);
      chk("reset_outputs", 64'({busy, slxyvalid, slxylast, slxywreply, slxyresp, slxyburden}), 64'd0);
      chk("reset_rdata", 64'(slxyrdata), 64'd0);
      rstnn = 1'b1;
      tick();

      for (int i = 0; i < 17; i++) begin
         bdn = i[0];
         if (tbl[i].wr) begin
            wbuf[0] = tbl[i].wd;
            wr_burst(tbl[i].addr, 0, tbl[i].sz, tbl[i].bu, tbl[i].st, resp);
            chk($sformatf("vec%0d_wresp", i), 64'(resp), 64'(tbl[i].ep));
         end else begin
            rd_burst(tbl[i].addr, 0, tbl[i].sz, tbl[i].bu, 1'b0);
            chk($sformatf("vec%0d_rdata", i), 64'(rdat[0]), 64'(tbl[i].er));
            chk($sformatf("vec%0d_rresp", i), 64'(rrsp[0]), 64'(tbl[i].ep));
         end
      end
      bdn = 1'b0;

      // INCR burst write then read back, one beat per cycle
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      wr_burst(32'h10, 3, 3'd2, 2'd1, 4'hF, resp);
      chk("incr_wresp", 64'(resp), 64'd0);
      rd_burst(32'h10, 3, 3'd2, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("incr_beat%0d", i), 64'(rdat[i]), 64'(i + 1));
      chk("incr_throughput", 64'(cyc), 64'd4);

      // len=7 read under alternating backpressure
      for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
      wr_burst(32'h40, 7, 3'd2, 2'd1, 4'hF, resp);
      rd_burst(32'h40, 7, 3'd2, 2'd1, 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("bp_beat%0d", i), 64'(rdat[i]), 64'h100 + 64'(i));
      chk("bp_cycles", 64'(cyc), 64'd15);

      // WRAP burst over a pre-filled 16-byte window
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
      wr_burst(32'h30, 3, 3'd2, 2'd1, 4'hF, resp);
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      wr_burst(32'h38, 3, 3'd2, 2'd2, 4'hF, resp);
`ifdef DCA_LPIXM_SRAM_RESPONDER_WRAP_EN
      chk("wrap_wresp", 64'(resp), 64'd0);
      rd_burst(32'h38, 3, 3'd2, 2'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_rd%0d", i), 64'(rdat[i]), 64'hA0 + 64'(i));
         chk($sformatf("wrap_rresp%0d", i), 64'(rrsp[i]), 64'd0);
      end
      rd_burst(32'h30, 3, 3'd2, 2'd1, 1'b0);
      chk("wrap_mem0", 64'(rdat[0]), 64'hA2);
      chk("wrap_mem1", 64'(rdat[1]), 64'hA3);
      chk("wrap_mem2", 64'(rdat[2]), 64'hA0);
      chk("wrap_mem3", 64'(rdat[3]), 64'hA1);
      rd_burst(32'h30, 2, 3'd2, 2'd2, 1'b0);
      for (int i = 0; i < 3; i++) chk($sformatf("wrap_badlen%0d", i), 64'(rrsp[i]), 64'd2);
`else
      chk("wrap_wresp", 64'(resp), 64'd2);
      rd_burst(32'h38, 3, 3'd2, 2'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_rd%0d", i), 64'(rdat[i]), 64'd0);
         chk($sformatf("wrap_rresp%0d", i), 64'(rrsp[i]), 64'd2);
      end
      rd_burst(32'h30, 3, 3'd2, 2'd1, 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("wrap_mem%0d", i), 64'(rdat[i]), 64'hC0 + 64'(i));
`endif

      // clear during beat 2 of a len=3 write
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + 32'(i);
      wr_burst(32'h60, 3, 3'd2, 2'd1, 4'hF, resp);
      for (int i = 0; i < 3; i++) begin
         slxqvalid = 1'b1; slxqwrite = 1'b1; slxqaddr = 32'h60; slxqlen = 8'd3;
         slxqsize = 3'd2; slxqburst = 2'd1; slxqwstrb = 4'hF;
         slxqwdata = 32'hF0 + 32'(i); slxqlast = 1'b0;
         if (i == 1) chk("clr_busy_mid", 64'(busy), 64'd1);
         if (i == 2) clear = 1'b1;
         tick();
      end
      clear = 1'b0;
      slxqvalid = 1'b0;
      chk("clr_state", 64'({busy, slxyvalid, slxqdready}), 64'd3);
      tick();
      chk("clr_no_reply", 64'(slxyvalid), 64'd0);
      rd_burst(32'h60, 3, 3'd2, 2'd1, 1'b0);
      chk("clr_mem0", 64'(rdat[0]), 64'hF0);
      chk("clr_mem1", 64'(rdat[1]), 64'hF1);
      chk("clr_mem2", 64'(rdat[2]), 64'hE2);
      chk("clr_mem3", 64'(rdat[3]), 64'hE3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
